// File: rtl/prince_sbox_seq_pkg.sv
// rtl/prince_sbox_seq_pkg.sv - shared constants, randomness word layout and FSM states for the PRINCE S-box sequencer
package prince_sbox_seq_pkg;

    localparam int RAND_W = 22;

    // Per-sample randomness word: r1 | r2 | r3 (6 bits each), then kl | mn (2 bits each)
    localparam int R_FIELD_W  = 6;
    localparam int KM_FIELD_W = 2;
    localparam int R1_OFF     = 0;
    localparam int R2_OFF     = R1_OFF + R_FIELD_W;
    localparam int R3_OFF     = R2_OFF + R_FIELD_W;
    localparam int KL_OFF     = R3_OFF + R_FIELD_W;
    localparam int MN_OFF     = KL_OFF + KM_FIELD_W;

    typedef enum logic [1:0] {
        R_EMPTY = 2'd0,
        R_WAIT  = 2'd1,
        R_FULL  = 2'd2
    } rnd_state_t;

endpackage

// File: rtl/prince_rand_buf.sv
// rtl/prince_rand_buf.sv - PRNG fetch FSM, one-word buffer and the rnd_o register bound to stage 1
// PRINCE_RAND_REFRESH_EN: refetch a fresh word after every accepted sample.
module prince_rand_buf
    import prince_sbox_seq_pkg::*;
#(
    parameter int RAND_W = prince_sbox_seq_pkg::RAND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              take,
    input  logic              rnd_ack,
    input  logic [RAND_W-1:0] rnd_data,
    output logic              rnd_req,
    output logic              rnd_full,
    output logic [RAND_W-1:0] rnd_o
);

    rnd_state_t        state_q;
    logic [RAND_W-1:0] word_q;
    logic [RAND_W-1:0] rnd_o_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= R_EMPTY;
            word_q  <= '0;
            rnd_o_q <= '0;
        end else begin
            case (state_q)
                R_EMPTY: state_q <= R_WAIT;
                R_WAIT: begin
                    if (rnd_ack) begin
                        word_q  <= rnd_data;
                        state_q <= R_FULL;
                    end
                end
                R_FULL: begin
                    if (take) begin
                        rnd_o_q <= word_q;
`ifdef PRINCE_RAND_REFRESH_EN
                        // The request is already up in the consuming cycle, so an ack here refills at once
                        if (rnd_ack) begin
                            word_q <= rnd_data;
                        end else begin
                            state_q <= R_WAIT;
                        end
`endif
                    end
                end
                default: state_q <= R_EMPTY;
            endcase
        end
    end

`ifdef PRINCE_RAND_REFRESH_EN
    assign rnd_req = (state_q == R_WAIT) | ((state_q == R_FULL) & take);
`else
    assign rnd_req = (state_q == R_WAIT);
`endif
    assign rnd_full = (state_q == R_FULL);
    assign rnd_o    = rnd_o_q;

endmodule

// File: rtl/prince_sbox_seq.sv
// rtl/prince_sbox_seq.sv - elastic stage-valid chain and handshake sequencer for the 3-share masked PRINCE S-box
// Per-sample randomness refresh is enabled by defining PRINCE_RAND_REFRESH_EN.
module prince_sbox_seq
    import prince_sbox_seq_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int RAND_W = prince_sbox_seq_pkg::RAND_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rnd_req,
    input  logic              rnd_ack,
    input  logic [RAND_W-1:0] rnd_data,
    output logic [RAND_W-1:0] rnd_o,
    output logic [STAGES-1:0] stage_en,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              rnd_full;
    logic              take;
    logic              all_full;

    prince_rand_buf #(
        .RAND_W (RAND_W)
    ) u_rand_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .take     (take),
        .rnd_ack  (rnd_ack),
        .rnd_data (rnd_data),
        .rnd_req  (rnd_req),
        .rnd_full (rnd_full),
        .rnd_o    (rnd_o)
    );

    // A stage advances when the consumer takes the tail or any stage ahead of it has a hole
    always_comb begin
        adv      = '0;
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]   = v_q[k] & (out_ready | ~all_full);
            all_full = all_full & v_q[k];
        end
    end

    assign in_ready = rnd_full & (~v_q[0] | adv[0]) & ~flush;
    assign take     = in_valid & in_ready;

    always_comb begin
        stage_en    = '0;
        stage_en[0] = take;
        for (int k = 1; k < STAGES; k++) begin
            stage_en[k] = adv[k-1] & ~flush;
        end
    end

    always_comb begin
        v_d   = '0;
        cnt_d = cnt_q;
        if (!flush) begin
            for (int k = 0; k < STAGES; k++) begin
                v_d[k] = stage_en[k] | (v_q[k] & ~adv[k]);
            end
            if (adv[STAGES-1]) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = v_q[STAGES-1];
    assign busy       = (|v_q) | ~rnd_full;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_prince_sbox_seq.sv
// tb/tb_prince_sbox_seq.sv - randomized self-checking bench for prince_sbox_seq against a slot-level reference model
module tb_prince_sbox_seq;

    localparam int S  = 4;
    localparam int RW = 22;
    localparam int CW = 16;
`ifdef PRINCE_RAND_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          rnd_ack = 1'b0;
    logic          flush = 1'b0;
    logic [RW-1:0] rnd_data = '0;
    logic          in_ready, out_valid, rnd_req, busy;
    logic [RW-1:0] rnd_o;
    logic [S-1:0]  stage_en;
    logic [CW-1:0] sample_cnt;

    always #5 clk = ~clk;

    prince_sbox_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rnd_req    (rnd_req),
        .rnd_ack    (rnd_ack),
        .rnd_data   (rnd_data),
        .rnd_o      (rnd_o),
        .stage_en   (stage_en),
        .flush      (flush),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: pipeline slots hold sample ids (0 = empty), plus the randomness word state
    int            slot[S];
    bit            m_have, m_fetch, m_boot;
    logic [RW-1:0] m_word, m_rnd_o;
    logic [CW-1:0] m_cnt;
    int            next_id, out_total, first_acc, first_out;
    logic [S-1:0]  s_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < S; k++) slot[k] = 0;
        m_have = 1'b0; m_fetch = 1'b0; m_boot = 1'b1;
        m_word = '0; m_rnd_o = '0; m_cnt = '0;
        next_id = 1; out_total = 0; first_acc = -1; first_out = -1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
        check({pfx, "_rnd_req"}, 32'(rnd_req), 32'd0);
        check({pfx, "_rnd_o"}, 32'(rnd_o), 32'd0);
        check({pfx, "_stage_en"}, 32'(stage_en), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd1);
        check({pfx, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b1; out_ready = 1'b0; rnd_ack = 1'b0; flush = 1'b0; rnd_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    // Called at posedge+1 with inputs already applied; checks this cycle, advances the model, waits for the next edge
    task automatic step();
        int            nxt[S];
        int            outgoing;
        bit            moved_in[S];
        bit            room, hs, take, occ;
        logic [S-1:0]  exp_en;
        #3;
        for (int k = 0; k < S; k++) begin
            nxt[k] = slot[k];
            moved_in[k] = 1'b0;
        end
        outgoing = 0;
        if (nxt[S-1] != 0 && out_ready) begin
            outgoing = nxt[S-1];
            nxt[S-1] = 0;
        end
        for (int k = S - 2; k >= 0; k--) begin
            if (nxt[k] != 0 && nxt[k+1] == 0) begin
                nxt[k+1] = nxt[k];
                nxt[k] = 0;
                moved_in[k+1] = 1'b1;
            end
        end
        room = (nxt[0] == 0);
        hs = in_valid && m_have && !flush && room;
        exp_en = '0;
        exp_en[0] = hs;
        for (int k = 1; k < S; k++) exp_en[k] = moved_in[k] && !flush;
        occ = 1'b0;
        for (int k = 0; k < S; k++) if (slot[k] != 0) occ = 1'b1;

        check("out_valid", 32'(out_valid), 32'(slot[S-1] != 0));
        check("in_ready", 32'(in_ready), 32'(m_have && !flush && room));
        check("rnd_req", 32'(rnd_req), 32'(m_fetch || (REFRESH && hs)));
        check("stage_en", 32'(stage_en), 32'(exp_en));
        check("busy", 32'(busy), 32'(occ || !m_have));
        check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
        check("rnd_o", 32'(rnd_o), 32'(m_rnd_o));
        s_en = stage_en;

        take = (outgoing != 0) && !flush;
        if (flush) begin
            for (int k = 0; k < S; k++) slot[k] = 0;
        end else begin
            for (int k = 0; k < S; k++) slot[k] = nxt[k];
            if (take) begin
                m_cnt++;
                out_total++;
                if (first_out < 0) first_out = cyc;
            end
        end
        if (hs) begin
            slot[0] = next_id;
            next_id++;
            m_rnd_o = m_word;
            if (first_acc < 0) first_acc = cyc;
        end
        if (m_boot) begin
            m_boot = 1'b0;
            m_fetch = 1'b1;
        end else if (m_fetch && rnd_ack) begin
            m_word = rnd_data;
            m_have = 1'b1;
            m_fetch = 1'b0;
        end else if (hs && REFRESH) begin
            if (rnd_ack) m_word = rnd_data;
            else begin
                m_have = 1'b0;
                m_fetch = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int            acc, o0, first_c, last_c;
        bit            dup;
        logic [RW-1:0] words[$];
        logic [RW-1:0] word_snap;

        // First word acked in cycle 3, steady input demand
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_ack = (cyc == 3);
            rnd_data = (cyc == 3) ? 22'h155AA3 : RW'($urandom);
            step();
            if (cyc == 5) check("t1_rnd_o", 32'(rnd_o), 32'h155AA3);
            if (cyc == 9) check("t1_cnt", 32'(sample_cnt), 32'd1);
        end
        check("t1_first_accept", 32'(first_acc), 32'd4);
        check("t1_first_out", 32'(first_out), 32'd8);

        // Ten back-to-back samples with the PRNG acking every cycle
        do_reset();
        out_ready = 1'b1; rnd_ack = 1'b1;
        acc = 0; first_c = -1; last_c = -1; words.delete();
        for (int i = 0; i < 30; i++) begin
            in_valid = (acc < 10);
            rnd_data = RW'(32'h1000 + cyc);
            step();
            if (s_en[0]) begin
                acc++;
                if (first_c < 0) first_c = cyc - 1;
                last_c = cyc - 1;
                words.push_back(rnd_o);
            end
        end
        check("t2_accepts", 32'(acc), 32'd10);
        check("t2_back_to_back", 32'(last_c - first_c), 32'd9);
        check("t2_cnt", 32'(sample_cnt), 32'd10);
        dup = 1'b0;
`ifdef PRINCE_RAND_REFRESH_EN
        for (int i = 0; i < words.size(); i++)
            for (int j = i + 1; j < words.size(); j++)
                if (words[i] == words[j]) dup = 1'b1;
        check("t2_rnd_distinct", 32'(dup), 32'd0);
`else
        for (int i = 0; i < words.size(); i++)
            if (words[i] != words[0]) dup = 1'b1;
        check("t2_rnd_const", 32'(dup), 32'd0);
`endif

        // Back-pressure: consumer stalled, pipeline fills to exactly STAGES samples
        in_valid = 1'b1; out_ready = 1'b0; rnd_ack = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            rnd_data = RW'($urandom);
            step();
            if (s_en[0]) acc++;
        end
        check("t3_accepts", 32'(acc), 32'(S));
        check("t3_in_ready_stall", 32'(in_ready), 32'd0);
        check("t3_stage_en_stall", 32'(stage_en), 32'd0);
        check("t3_out_valid_hold", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1; o0 = int'(sample_cnt);
        for (int i = 0; i < 8; i++) step();
        check("t3_drained", 32'(int'(sample_cnt) - o0), 32'(S));
        check("t3_empty", 32'(out_valid), 32'd0);

        // PRNG silent for six cycles mid-stream
        in_valid = 1'b1; out_ready = 1'b1; acc = 0;
        for (int i = 0; i < 20; i++) begin
            rnd_ack = !(i >= 5 && i < 11);
            rnd_data = RW'($urandom);
            step();
            if (i >= 6 && i < 12 && s_en[0]) acc++;
        end
`ifdef PRINCE_RAND_REFRESH_EN
        check("t4_stall_accepts", 32'(acc), 32'd0);
`else
        check("t4_stall_accepts", 32'(acc), 32'd6);
`endif
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t4_drain_out_valid", 32'(out_valid), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // Flush with three stages occupied and an output handshake in the same cycle
        out_ready = 1'b0; rnd_ack = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (acc < 3);
            rnd_data = RW'($urandom);
            step();
            if (s_en[0]) acc++;
        end
        check("t5_setup_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1; rnd_ack = 1'b0;
        o0 = int'(sample_cnt);
        word_snap = m_word;
        step();
        flush = 1'b0;
        check("t5_flush_out_valid", 32'(out_valid), 32'd0);
        check("t5_flush_cnt", 32'(sample_cnt), 32'(o0));
        check("t5_flush_busy", 32'(busy), 32'd0);
        step();
        check("t5_accept_after_flush", 32'(s_en[0]), 32'd1);
        check("t5_buffered_word", 32'(rnd_o), 32'(word_snap));
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 10) < 7;
            rnd_ack = ($urandom % 10) < 6;
            flush = ($urandom % 32) == 0;
            rnd_data = RW'($urandom);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a stream
        in_valid = 1'b1; out_ready = 1'b1; rnd_ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rnd_data = RW'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("arst");

        // Counter wraps after 2^16 completed samples
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; rnd_ack = 1'b1;
        for (int i = 0; i < 70000 && out_total < 65536; i++) begin
            rnd_data = RW'($urandom);
            step();
        end
        check("wrap_outputs", 32'(out_total), 32'd65536);
        check("wrap_cnt", 32'(sample_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
